// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage hazard/flush control bundle
// master = pipeline side driving ID state, slave = the scoreboard.
interface hazard_scoreboard_if #(
   parameter int CNT_W = 16
);
   logic             freeze;
   logic             fwd_en;
   logic [3:0]       id_src1;
   logic [3:0]       id_src2;
   logic             id_src1_used;
   logic             id_two_src;
   logic             id_wb_en;
   logic             id_mem_r_en;
   logic [3:0]       id_dest;
   logic             branch_taken;
   logic             hazard;
   logic             flush;
   logic [15:0]      busy_mask;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output freeze, fwd_en, id_src1, id_src2, id_src1_used, id_two_src,
             id_wb_en, id_mem_r_en, id_dest, branch_taken,
      input  hazard, flush, busy_mask, stall_count
   );

   modport slave (
      input  freeze, fwd_en, id_src1, id_src2, id_src1_used, id_two_src,
             id_wb_en, id_mem_r_en, id_dest, branch_taken,
      output hazard, flush, busy_mask, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage RAW scoreboard, branch flush FSM, stall counter
// Entry 0 is the instruction now in EXE; the oldest entry retires off the end.
module hazard_scoreboard #(
   parameter int DEPTH        = 2,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_scoreboard_if.slave   bus
);
   typedef struct packed {
      logic       valid;
      logic       wb_en;
      logic       mem_r_en;
      logic [3:0] dest;
   } entry_t;

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   localparam logic [1:0] RELOAD = 2'(FLUSH_CYCLES - 1);

   entry_t           entry_q [DEPTH];
   entry_t           entry_d [DEPTH];
   state_t           state_q;
   logic [1:0]       remaining_q;
   logic [CNT_W-1:0] count_q;
   logic             raw;
   logic             flush_w;
   logic             hazard_w;
   logic [15:0]      busy_w;

   function automatic logic hit(entry_t e, logic [3:0] r);
      return e.valid && e.wb_en && (e.dest == r);
   endfunction

   // With forwarding, only a load sitting in EXE can still be unresolved.
   always_comb begin
      raw    = 1'b0;
      busy_w = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (entry_q[k].valid && entry_q[k].wb_en)
            busy_w[entry_q[k].dest] = 1'b1;
         if (!bus.fwd_en || (k == 0 && entry_q[k].mem_r_en)) begin
            if ((bus.id_src1_used && hit(entry_q[k], bus.id_src1)) ||
                (bus.id_two_src   && hit(entry_q[k], bus.id_src2)))
               raw = 1'b1;
         end
      end
   end

   assign flush_w  = bus.branch_taken || (state_q == S_FLUSH);
   assign hazard_w = raw && !flush_w;

   always_comb begin
      if (flush_w || hazard_w)
         entry_d[0] = '0;
      else
         entry_d[0] = '{valid: 1'b1, wb_en: bus.id_wb_en,
                        mem_r_en: bus.id_mem_r_en, dest: bus.id_dest};
      for (int k = 1; k < DEPTH; k++)
         entry_d[k] = entry_q[k-1];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++)
            entry_q[k] <= '0;
      end else if (!bus.freeze) begin
         for (int k = 0; k < DEPTH; k++)
            entry_q[k] <= entry_d[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         remaining_q <= 2'd0;
      end else if (!bus.freeze) begin
         case (state_q)
            S_IDLE: begin
               if (bus.branch_taken && FLUSH_CYCLES > 1) begin
                  state_q     <= S_FLUSH;
                  remaining_q <= RELOAD;
               end
            end
            S_FLUSH: begin
               if (bus.branch_taken) begin
                  remaining_q <= RELOAD;
               end else if (remaining_q == 2'd1) begin
                  state_q     <= S_IDLE;
                  remaining_q <= 2'd0;
               end else begin
                  remaining_q <= remaining_q - 2'd1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               remaining_q <= 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         count_q <= '0;
      else if (!bus.freeze && hazard_w && (count_q != '1))
         count_q <= count_q + CNT_W'(1);
   end

   assign bus.hazard      = hazard_w;
   assign bus.flush       = flush_w;
   assign bus.busy_mask   = busy_w;
   assign bus.stall_count = count_q;
endmodule
